// File: rtl/irq_gateway_if.sv
// Peripheral bus bundle for irq_gateway. Signal names are taken from the
// gateway's point of view: *_i flow into the gateway and data_o flows out.
interface irq_gateway_if;
    logic        en_i;    // access strobe
    logic [3:0]  we_i;    // any nonzero value is a full 32-bit write
    logic [23:0] addr_i;  // register address
    logic [31:0] data_i;  // write data
    logic [31:0] data_o;  // registered read data

    modport master (output en_i, output we_i, output addr_i, output data_i, input  data_o);
    modport slave  (input  en_i, input  we_i, input  addr_i, input  data_i, output data_o);
endinterface

// File: rtl/irq_gateway.sv
// irq_gateway: per-source interrupt gateway in front of the interrupt
// controller. It synchronises the raw lines, applies polarity and trigger
// type, and holds one pending request per source until it is acknowledged.
// Optional feature macro: IRQ_EDGE_COUNT_EN. When it is defined, each edge
// source queues up to 15 extra edges and the OVF register is implemented.
// When it is undefined, a single queued-edge flag is kept and OVF reads 0.
module irq_gateway #(
    parameter int i_cnt = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [i_cnt:1]   src_i,
    output logic [i_cnt:1]   irq_o,
    input  logic [i_cnt:1]   iack_i,
    irq_gateway_if.slave     bus
);

`ifdef IRQ_EDGE_COUNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 1;
`endif
    localparam logic [CW-1:0] CNT_MAX = '1;

    localparam logic [23:0] ADDR_TRIG = 24'h000000;
    localparam logic [23:0] ADDR_POL  = 24'h000004;
    localparam logic [23:0] ADDR_PEND = 24'h000008;
    localparam logic [23:0] ADDR_OVF  = 24'h00000C;

    typedef enum logic [1:0] {IDLE, PEND, GAP} state_t;

    logic [i_cnt:1] trig_q;
    logic [i_cnt:1] pol_q;
    logic [i_cnt:1] ovf_q;
    logic [i_cnt:1] sync1_q;
    logic [i_cnt:1] sync_q;
    logic [i_cnt:1] prev_q;
    logic [i_cnt:1] edge_w;
    logic [i_cnt:1] trig_clr;
    logic [i_cnt:1] wdata_src;
    logic [31:0]    rd_val;
    logic [31:0]    data_q;
    logic           wr;
    logic           rd;
    logic           wr_trig;
    logic           wr_pol;

    // Bus decode: a write is any strobe with a nonzero byte-enable.
    assign wr        = bus.en_i & (|bus.we_i);
    assign rd        = bus.en_i & ~(|bus.we_i);
    assign wr_trig   = wr && (bus.addr_i == ADDR_TRIG);
    assign wr_pol    = wr && (bus.addr_i == ADDR_POL);
    assign wdata_src = bus.data_i[i_cnt:1];
    // Switching a source to level mode discards whatever edges it had queued.
    assign trig_clr  = wr_trig ? ~wdata_src : '0;

`ifdef IRQ_EDGE_COUNT_EN
    logic           wr_ovf;
    logic [i_cnt:1] ovf_clr;
    assign wr_ovf  = wr && (bus.addr_i == ADDR_OVF);
    assign ovf_clr = wr_ovf ? wdata_src : '0;
`endif

    // Configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_q <= '0;
            pol_q  <= '0;
        end else begin
            if (wr_trig) trig_q <= wdata_src;
            if (wr_pol)  pol_q  <= wdata_src;
        end
    end

    // Polarity fold, two-flop synchroniser and one-cycle delay for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= src_i ^ pol_q;
            sync_q  <= sync1_q;
            prev_q  <= sync_q;
        end
    end

    assign edge_w = sync_q & ~prev_q;

    genvar gi;
    generate
        for (gi = 1; gi <= i_cnt; gi++) begin : g_src
            state_t          state_q;
            logic            irq_q;
            logic [CW-1:0]   cnt_q;
            logic [CW-1:0]   cnt_d;
            logic            accept;
            logic            dec;
            logic            full;

            assign accept = trig_q[gi] & edge_w[gi] & (state_q != IDLE);
            assign dec    = (state_q == GAP) & trig_q[gi] & (cnt_q != '0);
            assign full   = (cnt_q == CNT_MAX);

            // Queue count: GAP consumes one entry, an edge during PEND/GAP adds
            // one; at saturation the add only survives if GAP consumed one.
            always_comb begin
                cnt_d = cnt_q;
                if (dec) cnt_d = cnt_q - CW'(1);
                if (accept && (dec || !full)) cnt_d = cnt_d + CW'(1);
                if (trig_clr[gi]) cnt_d = '0;
            end

            // Request FSM: IDLE -> PEND on trigger, PEND -> GAP on ack,
            // GAP -> PEND if an edge is queued, otherwise back to IDLE.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    case (state_q)
                        IDLE: begin
                            if (trig_q[gi] ? edge_w[gi] : sync_q[gi]) begin
                                state_q <= PEND;
                                irq_q   <= 1'b1;
                            end
                        end
                        PEND: begin
                            if (iack_i[gi]) begin
                                state_q <= GAP;
                                irq_q   <= 1'b0;
                            end
                        end
                        GAP: begin
                            if (trig_q[gi] && (cnt_q != '0)) begin
                                state_q <= PEND;
                                irq_q   <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                irq_q   <= 1'b0;
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            irq_q   <= 1'b0;
                        end
                    endcase
                end
            end

            assign irq_o[gi] = irq_q;

`ifdef IRQ_EDGE_COUNT_EN
            logic ovf_bit_q;
            // Sticky overflow: an accepted edge that finds the queue full.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) ovf_bit_q <= 1'b0;
                else       ovf_bit_q <= (ovf_bit_q & ~ovf_clr[gi]) | (accept & full);
            end
            assign ovf_q[gi] = ovf_bit_q;
`else
            assign ovf_q[gi] = 1'b0;
`endif
        end
    endgenerate

    // Read mux: sources occupy bits [i_cnt:1], bit 0 and upper bits read 0.
    always_comb begin
        rd_val = '0;
        case (bus.addr_i)
            ADDR_TRIG: rd_val[i_cnt:1] = trig_q;
            ADDR_POL:  rd_val[i_cnt:1] = pol_q;
            ADDR_PEND: rd_val[i_cnt:1] = irq_o;
            ADDR_OVF:  rd_val[i_cnt:1] = ovf_q;
            default:   rd_val = '0;
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   data_q <= '0;
        else if (rd) data_q <= rd_val;
    end

    assign bus.data_o = data_q;

endmodule

// File: tb/tb_irq_gateway.sv
// Directed testbench for irq_gateway with two sources. Expectations follow
// IRQ_EDGE_COUNT_EN so the same bench covers both builds.
module tb_irq_gateway;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N:1]   src_i = '0;
    logic [N:1]   irq_o;
    logic [N:1]   iack_i = '0;
    int           n_chk = 0;
    int           n_err = 0;
    logic [31:0]  rd;
    int           reqs;

    irq_gateway_if bus_if ();

    irq_gateway #(.i_cnt(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .src_i  (src_i),
        .irq_o  (irq_o),
        .iack_i (iack_i),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

`ifdef IRQ_EDGE_COUNT_EN
    localparam int  EXP_REQ3  = 4;
    localparam int  EXP_REQ17 = 16;
    localparam logic [31:0] EXP_OVF = 32'h2;
`else
    localparam int  EXP_REQ3  = 2;
    localparam int  EXP_REQ17 = 2;
    localparam logic [31:0] EXP_OVF = 32'h0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
        bus_if.en_i   = 1'b1;
        bus_if.we_i   = 4'hF;
        bus_if.addr_i = a;
        bus_if.data_i = d;
        tick();
        bus_if.en_i   = 1'b0;
        bus_if.we_i   = 4'h0;
    endtask

    task automatic bus_read(input logic [23:0] a, output logic [31:0] d);
        bus_if.en_i   = 1'b1;
        bus_if.we_i   = 4'h0;
        bus_if.addr_i = a;
        tick();
        bus_if.en_i   = 1'b0;
        d = bus_if.data_o;
    endtask

    task automatic do_reset();
        src_i  = '0;
        iack_i = '0;
        bus_if.en_i = 1'b0;
        bus_if.we_i = 4'h0;
        reset = 1'b1;
        tick();
        tick();
        #3 reset = 1'b0;
        tick();
    endtask

    // One 1-high/1-low pulse on source n; each gives one detected edge.
    task automatic pulse(input int n);
        src_i[n] = 1'b1;
        tick();
        src_i[n] = 1'b0;
        tick();
    endtask

    // Acknowledge every request on source n until it goes quiet. Each ack must
    // drop irq the next cycle, and a still-queued request must return one
    // cycle later.
    task automatic serve(input int n, input int exp, output int cnt);
        int quiet;
        cnt = 0;
        quiet = 0;
        for (int c = 0; c < 300 && quiet < 6; c++) begin
            if (irq_o[n]) begin
                cnt++;
                quiet = 0;
                iack_i[n] = 1'b1;
                tick();
                iack_i[n] = 1'b0;
                chk("ack_drops_irq", 32'(irq_o[n]), 32'h0);
                tick();
                if (cnt < exp) chk("regap_1cycle", 32'(irq_o[n]), 32'h1);
            end else begin
                quiet++;
                tick();
            end
        end
    endtask

    initial begin
        bus_if.en_i   = 1'b0;
        bus_if.we_i   = 4'h0;
        bus_if.addr_i = '0;
        bus_if.data_i = '0;

        // Reset state
        do_reset();
        chk("reset_irq", 32'(irq_o), 32'h0);
        chk("reset_data_o", bus_if.data_o, 32'h0);

        // Level mode: 3-cycle latency, re-request after ack while active
        src_i[1] = 1'b1;
        tick(); tick();
        chk("lvl_lat_not_yet", 32'(irq_o[1]), 32'h0);
        tick();
        chk("lvl_lat_3", 32'(irq_o[1]), 32'h1);
        chk("lvl_src2_idle", 32'(irq_o[2]), 32'h0);
        iack_i[1] = 1'b1;
        tick();
        iack_i[1] = 1'b0;
        chk("lvl_ack_low", 32'(irq_o[1]), 32'h0);
        tick(); tick();
        chk("lvl_rerequest", 32'(irq_o[1]), 32'h1);
        src_i[1] = 1'b0;
        tick(); tick(); tick();
        iack_i[1] = 1'b1;
        tick();
        iack_i[1] = 1'b0;
        tick(); tick(); tick(); tick();
        chk("lvl_dropped_stays0", 32'(irq_o[1]), 32'h0);

        // Edge mode: 3 edges queued during PEND
        do_reset();
        bus_write(24'h000000, 32'h2);
        pulse(1);
        tick();
        chk("edge_first_req", 32'(irq_o[1]), 32'h1);
        for (int i = 0; i < 3; i++) pulse(1);
        tick(); tick(); tick();
        serve(1, EXP_REQ3, reqs);
        chk("edge3_requests", 32'(reqs), 32'(EXP_REQ3));
        chk("edge3_idle_after", 32'(irq_o[1]), 32'h0);

        // Saturation: 17 edges during PEND
        do_reset();
        bus_write(24'h000000, 32'h2);
        pulse(1);
        tick();
        for (int i = 0; i < 17; i++) pulse(1);
        tick(); tick(); tick();
        bus_read(24'h00000C, rd);
        chk("ovf_after17", rd, EXP_OVF);
        serve(1, EXP_REQ17, reqs);
        chk("edge17_requests", 32'(reqs), 32'(EXP_REQ17));
        bus_write(24'h00000C, 32'h2);
        bus_read(24'h00000C, rd);
        chk("ovf_cleared", rd, 32'h0);

        // Polarity: active-low source with line held low
        do_reset();
        bus_write(24'h000004, 32'h2);
        tick(); tick();
        chk("pol_not_yet", 32'(irq_o[1]), 32'h0);
        tick();
        chk("pol_req", 32'(irq_o[1]), 32'h1);

        // Register readback and read-data hold
        do_reset();
        bus_write(24'h000000, 32'hFFFF_FFFF);
        bus_read(24'h000000, rd);
        chk("trig_readback", rd, 32'h6);
        bus_write(24'h000004, 32'h5);
        bus_read(24'h000004, rd);
        chk("pol_readback", rd, 32'h4);
        tick(); tick(); tick(); tick();
        bus_read(24'h000008, rd);
        chk("pend_readback", rd, 32'h4);
        bus_write(24'h000000, 32'h0);
        tick();
        chk("data_o_hold", bus_if.data_o, 32'h4);
        bus_read(24'h000010, rd);
        chk("unmapped_read", rd, 32'h0);

        // Reset in PEND with two queued edges
        do_reset();
        bus_write(24'h000000, 32'h2);
        pulse(1);
        tick();
        pulse(1);
        pulse(1);
        tick(); tick(); tick();
        chk("pre_reset_pend", 32'(irq_o[1]), 32'h1);
        reset = 1'b1;
        #1;
        chk("reset_async_irq", 32'(irq_o), 32'h0);
        #3 reset = 1'b0;
        tick();
        bus_read(24'h000000, rd);
        chk("post_reset_trig", rd, 32'h0);
        bus_read(24'h000004, rd);
        chk("post_reset_pol", rd, 32'h0);
        bus_read(24'h000008, rd);
        chk("post_reset_pend", rd, 32'h0);
        bus_read(24'h00000C, rd);
        chk("post_reset_ovf", rd, 32'h0);
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (irq_o != '0) reqs++;
        end
        chk("no_ghost_request", 32'(reqs), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
